// File: rtl/tape_byte_decoder.sv
// tape_byte_decoder: measures rising-edge periods of the tape audio bit, tracks pilot/sync/data and assembles bytes
// Ports: clk, reset (sync, active-high), aud (async comparator bit),
//        byte_out/byte_valid/byte_ready (one-entry holding register handshake),
//        in_block (PILOT or DATA), block_end (1-cycle pulse when DATA ends), overrun (sticky).
module tape_byte_decoder #(
    parameter int CLK_FREQ    = 27000000,
    parameter int CNT_W       = 17,
    parameter int SYNC_MIN    = CLK_FREQ / 4000,
    parameter int SYNC_MAX    = CLK_FREQ / 2300,
    parameter int BIT_THRESH  = CLK_FREQ / 1364,
    parameter int PILOT_MIN   = CLK_FREQ / 900,
    parameter int PILOT_MAX   = CLK_FREQ / 650,
    parameter int TIMEOUT     = CLK_FREQ / 400,
    parameter int PILOT_COUNT = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       aud,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       in_block,
    output logic       block_end,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, PILOT, DATA} state_t;
    localparam int PC_W = $clog2(PILOT_COUNT + 1);
    localparam logic [CNT_W-1:0] C_SYNC_MIN   = CNT_W'(SYNC_MIN);
    localparam logic [CNT_W-1:0] C_SYNC_MAX   = CNT_W'(SYNC_MAX);
    localparam logic [CNT_W-1:0] C_BIT_THRESH = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] C_PILOT_MIN  = CNT_W'(PILOT_MIN);
    localparam logic [CNT_W-1:0] C_PILOT_MAX  = CNT_W'(PILOT_MAX);
    localparam logic [CNT_W-1:0] C_TIMEOUT    = CNT_W'(TIMEOUT);
    state_t           state;
    logic             aud_m, aud_s, aud_s_d;
    logic [CNT_W-1:0] counter;
    logic [PC_W-1:0]  pilot_cnt;
    logic             first_edge;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic             rise, timeout, is_sync, is_bit0, is_bit1, is_pilot;
    logic [7:0]       next_byte;
    // counter holds the period since the previous rise at the moment rise is high
    always_comb begin
        rise      = aud_s & ~aud_s_d;
        timeout   = counter == C_TIMEOUT;
        is_sync   = counter >= C_SYNC_MIN && counter < C_SYNC_MAX;
        is_bit0   = counter >= C_SYNC_MAX && counter < C_BIT_THRESH;
        is_bit1   = counter >= C_BIT_THRESH && counter < C_PILOT_MIN;
        is_pilot  = counter >= C_PILOT_MIN && counter <= C_PILOT_MAX;
        next_byte = {shreg[6:0], is_bit1};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            aud_m      <= 1'b0;
            aud_s      <= 1'b0;
            aud_s_d    <= 1'b0;
            counter    <= '0;
            pilot_cnt  <= '0;
            first_edge <= 1'b1;
            bitcnt     <= '0;
            shreg      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            in_block   <= 1'b0;
            block_end  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            aud_m     <= aud;
            aud_s     <= aud_m;
            aud_s_d   <= aud_s;
            counter   <= rise ? CNT_W'(1) : timeout ? counter : counter + 1'b1;
            block_end <= 1'b0;
            // a load later in this block overrides the handshake clear
            if (byte_valid && byte_ready)
                byte_valid <= 1'b0;
            if (rise && first_edge) begin
                first_edge <= 1'b0;
            end else if (rise && state == IDLE) begin
                pilot_cnt <= is_pilot ? pilot_cnt + 1'b1 : '0;
                if (is_pilot && pilot_cnt == PC_W'(PILOT_COUNT - 1)) begin
                    state    <= PILOT;
                    in_block <= 1'b1;
                end
            end else if (rise && state == PILOT && is_sync) begin
                state  <= DATA;
                bitcnt <= '0;
                shreg  <= '0;
            end else if (rise && state == DATA && (is_bit0 || is_bit1)) begin
                shreg  <= next_byte;
                bitcnt <= bitcnt + 1'b1;
                if (bitcnt == 3'd7) begin
                    byte_out   <= next_byte;
                    byte_valid <= 1'b1;
                    if (byte_valid && !byte_ready)
                        overrun <= 1'b1;
                end
            end else if ((rise && state != IDLE && !(state == PILOT && is_pilot)) ||
                         (timeout && state != IDLE)) begin
                state      <= IDLE;
                in_block   <= 1'b0;
                pilot_cnt  <= '0;
                first_edge <= 1'b1;
                block_end  <= state == DATA;
            end
        end
    end
endmodule

// File: tb/tb_tape_byte_decoder.sv
// tb_tape_byte_decoder: scenario tasks plus a byte scoreboard for tape_byte_decoder (scaled clock rate)
module tb_tape_byte_decoder;
    // CLK_FREQ=54000 gives SYNC 13..22, bit0 23..38, bit1 39..59, pilot 60..83, timeout 135
    localparam int P_PILOT = 70;
    localparam int P_SYNC  = 18;
    localparam int P_BIT0  = 30;
    localparam int P_BIT1  = 50;
    localparam int P_GLTCH = 10;
    logic       clk = 1'b0, reset = 1'b1, aud = 1'b0, byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, in_block, block_end, overrun;
    int         errors = 0, checks = 0, be_cnt = 0, valid_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    always #5 clk = ~clk;
    tape_byte_decoder #(.CLK_FREQ(54000), .CNT_W(8), .PILOT_COUNT(16)) dut (
        .clk(clk), .reset(reset), .aud(aud), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .in_block(in_block), .block_end(block_end), .overrun(overrun)
    );
    task automatic pulse(input int n);
        aud = 1'b1;
        repeat (n / 2) @(negedge clk);
        aud = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask
    task automatic pilot(input int k);
        repeat (k) pulse(P_PILOT);
    endtask
    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 7; i > 7 - nb; i--) pulse(b[i] ? P_BIT1 : P_BIT0);
    endtask
    task automatic note_byte(input logic [7:0] b);
        if (exp_q.size() != 0 && !byte_ready) begin
            void'(exp_q.pop_back());
            exp_ovr = 1'b1;
        end
        exp_q.push_back(b);
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        aud = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (block_end) be_cnt++;
            if (byte_valid) valid_cnt++;
            if (byte_valid && byte_ready && !reset) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handshake: got byte %h, expected no byte", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if (byte_out !== e) begin
                        errors++;
                        $display("FAIL handshake: got byte %h, expected %h", byte_out, e);
                    end
                end
            end
        end
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL reset_in_block: got %b expected 0", in_block); end
        checks++; if (block_end !== 1'b0) begin errors++; $display("FAIL reset_block_end: got %b expected 0", block_end); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
    endtask
    task automatic test_pilot();
        int v0, b0;
        do_reset();
        byte_ready = 1'b1;
        v0 = valid_cnt;
        b0 = be_cnt;
        pilot(16);
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL pilot_15: in_block got %b expected 0", in_block); end
        pulse(P_PILOT);
        checks++; if (in_block !== 1'b1) begin errors++; $display("FAIL pilot_16: in_block got %b expected 1", in_block); end
        pilot(10);
        checks++; if (in_block !== 1'b1) begin errors++; $display("FAIL pilot_hold: in_block got %b expected 1", in_block); end
        repeat (200) @(negedge clk);
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL pilot_timeout: in_block got %b expected 0", in_block); end
        checks++; if (be_cnt - b0 != 0) begin errors++; $display("FAIL pilot_silent: block_end pulses got %0d expected 0", be_cnt - b0); end
        checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL pilot_nobyte: valid cycles got %0d expected 0", valid_cnt - v0); end
    endtask
    task automatic test_byte_a5();
        int v0, b0;
        do_reset();
        byte_ready = 1'b1;
        v0 = valid_cnt;
        b0 = be_cnt;
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'hA5, 8);
        note_byte(8'hA5);
        pulse(P_PILOT);
        repeat (200) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL a5_delivered: pending got %0d expected 0", exp_q.size()); end
        checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a5_valid_len: valid cycles got %0d expected 1", valid_cnt - v0); end
        checks++; if (be_cnt - b0 != 1) begin errors++; $display("FAIL a5_block_end: pulses got %0d expected 1", be_cnt - b0); end
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL a5_in_block: got %b expected 0", in_block); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL a5_overrun: got %b expected 0", overrun); end
    endtask
    task automatic test_back_to_back();
        do_reset();
        byte_ready = 1'b1;
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'hC3, 8);
        note_byte(8'hC3);
        send_bits(8'h3C, 8);
        note_byte(8'h3C);
        pulse(P_PILOT);
        repeat (200) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_delivered: pending got %0d expected 0", exp_q.size()); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL b2b_overrun: got %b expected %b", overrun, exp_ovr); end
    endtask
    task automatic test_overrun();
        do_reset();
        byte_ready = 1'b0;
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'h12, 8);
        note_byte(8'h12);
        send_bits(8'h34, 8);
        note_byte(8'h34);
        pulse(P_PILOT);
        repeat (200) @(negedge clk);
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL ovr_model: pending got %0d expected 1", exp_q.size()); end
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", byte_valid); end
        checks++; if (byte_out !== exp_q[0]) begin errors++; $display("FAIL ovr_byte: got %h expected %h", byte_out, exp_q[0]); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b expected %b", overrun, exp_ovr); end
    endtask
    task automatic test_ready_pulse();
        @(negedge clk);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        @(negedge clk);
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rdy_valid: got %b expected 0", byte_valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rdy_delivered: pending got %0d expected 0", exp_q.size()); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL rdy_sticky: overrun got %b expected %b", overrun, exp_ovr); end
    endtask
    task automatic test_timeout();
        int n, v0, b0;
        do_reset();
        byte_ready = 1'b1;
        v0 = valid_cnt;
        b0 = be_cnt;
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'hA0, 3);
        aud = 1'b1;
        @(negedge clk);
        aud = 1'b0;
        n = 1;
        while (!block_end && n < 400) begin
            @(negedge clk);
            n++;
        end
        // 2 sync stages + 1 edge detect, 135 counts, then one cycle to register block_end
        checks++; if (n != 138) begin errors++; $display("FAIL to_latency: block_end after %0d cycles expected 138", n); end
        @(negedge clk);
        checks++; if (block_end !== 1'b0) begin errors++; $display("FAIL to_pulse: block_end got %b expected 0", block_end); end
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL to_in_block: got %b expected 0", in_block); end
        repeat (3) @(negedge clk);
        checks++; if (be_cnt - b0 != 1) begin errors++; $display("FAIL to_be_count: got %0d expected 1", be_cnt - b0); end
        checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL to_nobyte: valid cycles got %0d expected 0", valid_cnt - v0); end
    endtask
    task automatic test_pilot_break();
        do_reset();
        pilot(12);
        pulse(P_BIT0);
        pilot(16);
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL brk_restart: in_block got %b expected 0", in_block); end
        pulse(P_PILOT);
        checks++; if (in_block !== 1'b1) begin errors++; $display("FAIL brk_arm: in_block got %b expected 1", in_block); end
    endtask
    task automatic test_glitch_data();
        int n;
        do_reset();
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'h80, 2);
        pulse(P_GLTCH);
        aud = 1'b1;
        n = 0;
        while (!block_end && n < 400) begin
            @(negedge clk);
            n++;
        end
        aud = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL gl_latency: block_end after %0d cycles expected 3", n); end
        @(negedge clk);
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL gl_in_block: got %b expected 0", in_block); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        byte_ready = 1'b0;
        pilot(20);
        pulse(P_SYNC);
        send_bits(8'h5A, 8);
        note_byte(8'h5A);
        send_bits(8'hFF, 3);
        checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL rm_pending: byte_valid got %b expected 1", byte_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL rm_byte_out: got %h expected 00", byte_out); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rm_byte_valid: got %b expected 0", byte_valid); end
        checks++; if (in_block !== 1'b0) begin errors++; $display("FAIL rm_in_block: got %b expected 0", in_block); end
        checks++; if (block_end !== 1'b0) begin errors++; $display("FAIL rm_block_end: got %b expected 0", block_end); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun: got %b expected 0", overrun); end
        reset = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask
    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_pilot();
        test_byte_a5();
        test_back_to_back();
        test_overrun();
        test_ready_pulse();
        test_timeout();
        test_pilot_break();
        test_glitch_data();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
